// File: rtl/comp_sort_ctrl.sv
// Frame sorter: loads Depth words, bubble-sorts them in place with one shared comparator
// (one compare per cycle, ascending, stable), then streams the sorted frame out.
module comp_sort_ctrl #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic [7:0]       swap_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);
  localparam logic [PtrW-1:0] LastCmp = PtrW'(Depth - 2);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   mem_q [Depth];
  logic [Width-1:0]   mem_d [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    idx_q, idx_d;
  logic [PtrW-1:0]    pass_q, pass_d;
  logic               pass_swap_q, pass_swap_d;
  logic [7:0]         swap_cnt_q, swap_cnt_d;

  logic [Width-1:0]   cmp_a, cmp_b;
  logic [1:0]         cmp_res;
  logic               do_swap;

  // Shared magnitude comparator: 2'b10 for a>b, 2'b01 for a<b, 2'b00 for equal.
  function automatic logic [1:0] cmp_fn(input logic [Width-1:0] a, input logic [Width-1:0] b);
    if (a > b)      return 2'b10;
    else if (a < b) return 2'b01;
    else            return 2'b00;
  endfunction

  assign cmp_a   = mem_q[idx_q];
  assign cmp_b   = mem_q[idx_q + PtrW'(1)];
  assign cmp_res = cmp_fn(cmp_a, cmp_b);
  // Only strictly-greater swaps, so equal words keep their original order.
  assign do_swap = (cmp_res == 2'b10);

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    pass_swap_d = pass_swap_q;
    swap_cnt_d  = swap_cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    busy_o      = 1'b0;

    case (state_q)
      StLoad: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          mem_d[wr_ptr_q] = in_data_i;
          if (wr_ptr_q == '0) swap_cnt_d = '0;
          if (wr_ptr_q == LastIdx) begin
            wr_ptr_d    = '0;
            idx_d       = '0;
            pass_d      = '0;
            pass_swap_d = 1'b0;
            state_d     = StSort;
          end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end
        end
      end
      StSort: begin
        busy_o = 1'b1;
        if (do_swap) begin
          mem_d[idx_q]            = cmp_b;
          mem_d[idx_q + PtrW'(1)] = cmp_a;
          if (swap_cnt_q != 8'hff) swap_cnt_d = swap_cnt_q + 8'd1;
        end
        pass_swap_d = pass_swap_q | do_swap;
        if (idx_q == LastCmp) begin
          // Pass done: stop early on a clean pass, or after Depth-1 passes.
          if (!(pass_swap_q || do_swap) || (pass_q == LastCmp)) begin
            rd_ptr_d = '0;
            state_d  = StDrain;
          end else begin
            idx_d       = '0;
            pass_d      = pass_q + PtrW'(1);
            pass_swap_d = 1'b0;
          end
        end else begin
          idx_d = idx_q + PtrW'(1);
        end
      end
      StDrain: begin
        out_valid_o = 1'b1;
        out_data_o  = mem_q[rd_ptr_q];
        out_last_o  = (rd_ptr_q == LastIdx);
        if (out_ready_i) begin
          if (rd_ptr_q == LastIdx) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = StLoad;
          end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      pass_swap_q <= 1'b0;
      swap_cnt_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      pass_swap_q <= pass_swap_d;
      swap_cnt_q  <= swap_cnt_d;
      for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign swap_cnt_o = swap_cnt_q;

endmodule

// File: tb/tb_comp_sort_ctrl.sv
// Self-checking bench for comp_sort_ctrl: a frame-level model (sorted order, inversion count,
// pass count) feeds an expected-output queue that a negedge monitor checks every cycle.
module tb_comp_sort_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready_o;
  logic [1:0] in_data = '0;
  logic       out_valid_o;
  logic       out_ready = 1'b1;
  logic [1:0] out_data_o;
  logic       out_last_o;
  logic       busy_o;
  logic [7:0] swap_cnt_o;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];
  int exp_swaps = 0;
  int exp_busy  = 0;
  int busy_cnt  = 0;
  int last_busy = -1;

  comp_sort_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .busy_o     (busy_o),
    .swap_cnt_o (swap_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every cycle, outputs must match the front of the expected sorted frame.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (!out_valid_o) begin
        chk("idle_out_data", int'(out_data_o), 0);
        chk("idle_out_last", int'(out_last_o), 0);
      end else if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got word %0d, expected no output", out_data_o);
      end else begin
        chk("out_data", int'(out_data_o), exp_q[0]);
        chk("out_last", int'(out_last_o), int'(exp_q.size() == 1));
        chk("swap_cnt_drain", int'(swap_cnt_o), exp_swaps);
        if (out_ready) begin
          if (exp_q.size() == 1) begin
            chk("busy_cycles", busy_cnt, exp_busy);
            last_busy = busy_cnt;
            busy_cnt  = 0;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Model: stable ascending order; bubble swaps = inversions; passes limited by the
  // largest leftward displacement any word needs, plus one clean pass, capped at D-1.
  task automatic load_frame(input int f[D], input bit gaps);
    int s[D];
    int inv, kmax, k, t, passes;
    inv = 0;
    kmax = 0;
    for (int i = 0; i < D; i++) begin
      k = 0;
      for (int j = 0; j < i; j++) if (f[j] > f[i]) k++;
      inv += k;
      if (k > kmax) kmax = k;
    end
    s = f;
    for (int i = 1; i < D; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    passes = (kmax + 1 < D - 1) ? kmax + 1 : D - 1;
    exp_swaps = inv;
    exp_busy  = passes * (D - 1);
    for (int i = 0; i < D; i++) exp_q.push_back(s[i]);
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      in_data  = 2'(f[i]);
      @(posedge clk); #1;
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (in_ready_o && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(in_ready_o), 1);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_out_last", int'(out_last_o), 0);
    chk("rst_out_data", int'(out_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_swap_cnt", int'(swap_cnt_o), 0);

    // 1: already sorted
    load_frame('{0, 1, 2, 3}, 1'b0);
    wait_done("t1_done");
    chk("t1_swaps", int'(swap_cnt_o), 0);
    chk("t1_busy", last_busy, 3);

    // 2: reversed
    load_frame('{3, 2, 1, 0}, 1'b0);
    wait_done("t2_done");
    chk("t2_swaps", int'(swap_cnt_o), 6);
    chk("t2_busy", last_busy, 9);

    // 3: duplicates must not be swapped
    load_frame('{2, 0, 2, 1}, 1'b0);
    wait_done("t3_done");
    chk("t3_swaps", int'(swap_cnt_o), 3);
    chk("t3_busy", last_busy, 9);

    // 4: in_valid gaps
    load_frame('{1, 3, 0, 2}, 1'b1);
    wait_done("t4_done");
    chk("t4_swaps", int'(swap_cnt_o), 3);
    chk("t4_busy", last_busy, 9);

    // 5: output backpressure at rd_ptr=1
    load_frame('{0, 1, 2, 3}, 1'b0);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (out_valid_o) begin
        ok = 1;
        break;
      end
    end
    chk("t5_drain_start", int'(ok), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      chk("t5_stall_data", int'(out_data_o), 1);
      chk("t5_stall_last", int'(out_last_o), 0);
      @(posedge clk); #1;
    end
    chk("t5_stall_data_end", int'(out_data_o), 1);
    out_ready = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid_o && out_last_o) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t5_last_seen", int'(ok), 1);
    chk("t5_last_data", int'(out_data_o), 3);
    @(posedge clk); #1;
    chk("t5_in_ready_after", int'(in_ready_o), 1);
    chk("t5_out_valid_after", int'(out_valid_o), 0);
    chk("t5_busy", last_busy, 3);

    // 6: reset in 2nd SORT cycle aborts the frame
    load_frame('{3, 2, 1, 0}, 1'b0);
    chk("t6_busy_sort1", int'(busy_o), 1);
    @(posedge clk); #1;
    chk("t6_swap_mid", int'(swap_cnt_o), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_in_ready", int'(in_ready_o), 1);
    chk("t6_out_valid", int'(out_valid_o), 0);
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_swap_cnt", int'(swap_cnt_o), 0);
    load_frame('{2, 3, 1, 0}, 1'b0);
    wait_done("t6_done");
    chk("t6_swaps", int'(swap_cnt_o), 5);
    chk("t6_busy_len", last_busy, 9);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
